scan_sram_bridge: RTL and testbench
===================================

SCAN_SRAM_BRIDGE -- requirements
Module: scan_sram_bridge

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of clk cycles an access waits for sram_ready/reg_ready.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth for scan-domain control inputs.
REQ-003 The block SHALL have one clock and a synchronous active-high reset.
REQ-004 clk  input  1  the single clock, rising-edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 scan_id  input  1  group select from the group mux, scan domain.
REQ-007 static_wen  input  1  level write request, scan domain.
REQ-008 static_ren  input  1  level read request, scan domain.
REQ-009 static_addr  input  20  access address, quasi-static.
REQ-010 static_wdata  input  32  write data, quasi-static.
REQ-011 static_rdata  output  32  read result.
REQ-012 static_ready  output  1  access complete.
REQ-013 sram_ren, sram_wen  output  1 each  SRAM strobes.
REQ-014 sram_addr  output  11  SRAM word address; sram_wdata  output  32; sram_rdata  input  32; sram_ready  input  1.
REQ-015 reg_wen, reg_ren  output  1 each; cr_wdata  output  17; cr_rdata  input  17; sr_rdata  input  15; reg_ready  input  1.

Function
REQ-016 scan_id, static_wen, static_ren SHALL each pass through a SYNC_STAGES-flop synchronizer; all decisions use synchronized values (sid, swen, sren).
REQ-017 A request SHALL start in IDLE on a 0->1 edge of swen or sren while sid=1; edges with sid=0 are ignored.
REQ-018 Simultaneous swen and sren rising edges SHALL be treated as a write only.
REQ-019 On start, static_addr and static_wdata SHALL be captured into internal registers; later changes do not affect the access.
REQ-020 Decode: addr[19:18]=00 SRAM (sram_addr=addr[10:0]); 01 with addr[0]=0 control register; 01 with addr[0]=1 status register; 10/11 unmapped.
REQ-021 FSM states: IDLE, SRAM, REG, DONE; IDLE->SRAM/REG/DONE per decode on start.
REQ-022 SRAM: sram_wen (write) or sram_ren (read) SHALL assert the cycle after start and hold until the cycle sram_ready=1 is sampled, deasserting the next cycle; on that cycle read data sram_rdata is captured; -> DONE.
REQ-023 REG: reg_wen (with cr_wdata=wdata[16:0]) or reg_ren SHALL follow the same hold-until-reg_ready rule; reads capture {15'b0,cr_rdata} or {17'b0,sr_rdata}; -> DONE.
REQ-024 Status-register write and any unmapped access SHALL issue no strobe and go directly to DONE; unmapped reads return 32'h0000_0000.
REQ-025 A wait counter SHALL count cycles in SRAM/REG; reaching TIMEOUT with no ready deasserts the strobe, sets static_rdata=32'hDEAD_BEEF (reads only), -> DONE.
REQ-026 DONE: static_ready=1; remain until swen=0 and sren=0, then static_ready=0 and -> IDLE (4-phase handshake).
REQ-027 static_rdata SHALL update only on read completion and hold otherwise; writes leave it unchanged.
REQ-028 sram_addr, sram_wdata, cr_wdata SHALL hold captured values between accesses.
REQ-029 sid falling mid-access SHALL NOT abort the access.

Reset
REQ-030 rst SHALL set FSM=IDLE, synchronizers=0, counter=0, all strobes=0, static_ready=0, static_rdata=0, sram_addr=0, sram_wdata=0, cr_wdata=0.
REQ-031 rst asserted mid-access SHALL drop any strobe the next cycle; a still-high swen/sren after reset SHALL NOT start an access without a fresh rising edge.

Verification
REQ-032 sid=1, addr=20'h00123, wdata=32'hCAFE_F00D, wen rises; sram_ready after 3 cycles -> sram_wen high 3+1 cycles, sram_addr=11'h123, static_ready=1 until wen falls.
REQ-033 Read addr=20'h00007, sram_rdata=32'h1234_5678 with ready 1 cycle later -> static_rdata=32'h1234_5678, static_ready=1.
REQ-034 Read addr=20'h40000, cr_rdata=17'h1_ABCD -> static_rdata=32'h0001_ABCD; read addr=20'h40001, sr_rdata=15'h7FFF -> 32'h0000_7FFF.
REQ-035 SRAM read, sram_ready held 0 -> sram_ren deasserts after 255 cycles, static_rdata=32'hDEAD_BEEF.
REQ-036 wen and ren rise together at addr 20'h80000 -> no strobe, static_ready=1 within SYNC_STAGES+2 cycles, static_rdata unchanged.
REQ-037 rst during SRAM wait -> sram_ren=0 next cycle, static_ready=0, no new access while ren stays high.

Source files
------------

// File: rtl/scan_sram_bridge_if.sv
// Signal bundle between the scan-domain static access port and the SRAM / register targets.
interface scan_sram_bridge_if;
  logic        scan_id;
  logic        static_wen;
  logic        static_ren;
  logic [19:0] static_addr;
  logic [31:0] static_wdata;
  logic [31:0] static_rdata;
  logic        static_ready;

  logic        sram_ren;
  logic        sram_wen;
  logic [10:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ready;

  logic        reg_wen;
  logic        reg_ren;
  logic [16:0] cr_wdata;
  logic [16:0] cr_rdata;
  logic [14:0] sr_rdata;
  logic        reg_ready;

  modport slave (
    input  scan_id, static_wen, static_ren, static_addr, static_wdata,
    output static_rdata, static_ready,
    output sram_ren, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata, sram_ready,
    output reg_wen, reg_ren, cr_wdata,
    input  cr_rdata, sr_rdata, reg_ready
  );

  modport master (
    output scan_id, static_wen, static_ren, static_addr, static_wdata,
    input  static_rdata, static_ready,
    input  sram_ren, sram_wen, sram_addr, sram_wdata,
    output sram_rdata, sram_ready,
    input  reg_wen, reg_ren, cr_wdata,
    output cr_rdata, sr_rdata, reg_ready
  );
endinterface

// File: rtl/scan_sram_bridge.sv
// Bridges level-signalled scan-domain requests to SRAM / control / status targets.
// Start is SYNC_STAGES+1 cycles after a request edge; strobes hold until ready or TIMEOUT, 4-phase done handshake.
module scan_sram_bridge #(
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  scan_sram_bridge_if.slave bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SRAM, ST_REG, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sid_sync_q, wen_sync_q, ren_sync_q, fill_q;
  logic                   wen_prev_q, ren_prev_q;
  logic                   sram_wen_q, sram_wen_d, sram_ren_q, sram_ren_d;
  logic                   reg_wen_q, reg_wen_d, reg_ren_q, reg_ren_d;
  logic                   is_wr_q, is_wr_d, is_sr_q, is_sr_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [10:0]            sram_addr_q, sram_addr_d;
  logic [31:0]            sram_wdata_q, sram_wdata_d;
  logic [16:0]            cr_wdata_q, cr_wdata_d;

  logic sid, swen, sren, primed, wen_rise, ren_rise, start, wr_start, timeout;

  assign sid    = sid_sync_q[SYNC_STAGES-1];
  assign swen   = wen_sync_q[SYNC_STAGES-1];
  assign sren   = ren_sync_q[SYNC_STAGES-1];
  assign primed = fill_q[SYNC_STAGES-1];

  // prev flags sit at 1 until the chains hold real samples, so a level still high out of reset is not an edge
  assign wen_rise = primed & swen & ~wen_prev_q;
  assign ren_rise = primed & sren & ~ren_prev_q;
  assign start    = sid & (wen_rise | ren_rise);
  assign wr_start = wen_rise;
  assign timeout  = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sram_wen_d   = sram_wen_q;
    sram_ren_d   = sram_ren_q;
    reg_wen_d    = reg_wen_q;
    reg_ren_d    = reg_ren_q;
    is_wr_d      = is_wr_q;
    is_sr_d      = is_sr_q;
    rdata_d      = rdata_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    cr_wdata_d   = cr_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_wr_d = wr_start;
          is_sr_d = bus.static_addr[0];
          cnt_d   = '0;
          unique case (bus.static_addr[19:18])
            2'b00: begin
              state_d     = ST_SRAM;
              sram_addr_d = bus.static_addr[10:0];
              sram_wen_d  = wr_start;
              sram_ren_d  = ~wr_start;
              if (wr_start) sram_wdata_d = bus.static_wdata;
            end
            2'b01: begin
              if (wr_start && bus.static_addr[0]) begin
                state_d = ST_DONE;
              end else begin
                state_d   = ST_REG;
                reg_wen_d = wr_start;
                reg_ren_d = ~wr_start;
                if (wr_start) cr_wdata_d = bus.static_wdata[16:0];
              end
            end
            default: begin
              state_d = ST_DONE;
              if (!wr_start) rdata_d = 32'h0000_0000;
            end
          endcase
        end
      end
      ST_SRAM: begin
        if (bus.sram_ready) begin
          sram_wen_d = 1'b0;
          sram_ren_d = 1'b0;
          state_d    = ST_DONE;
          if (!is_wr_q) rdata_d = bus.sram_rdata;
        end else if (timeout) begin
          sram_wen_d = 1'b0;
          sram_ren_d = 1'b0;
          state_d    = ST_DONE;
          if (!is_wr_q) rdata_d = 32'hDEAD_BEEF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REG: begin
        if (bus.reg_ready) begin
          reg_wen_d = 1'b0;
          reg_ren_d = 1'b0;
          state_d   = ST_DONE;
          if (!is_wr_q) rdata_d = is_sr_q ? {17'b0, bus.sr_rdata} : {15'b0, bus.cr_rdata};
        end else if (timeout) begin
          reg_wen_d = 1'b0;
          reg_ren_d = 1'b0;
          state_d   = ST_DONE;
          if (!is_wr_q) rdata_d = 32'hDEAD_BEEF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (!swen && !sren) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sid_sync_q   <= '0;
      wen_sync_q   <= '0;
      ren_sync_q   <= '0;
      fill_q       <= '0;
      wen_prev_q   <= 1'b1;
      ren_prev_q   <= 1'b1;
      sram_wen_q   <= 1'b0;
      sram_ren_q   <= 1'b0;
      reg_wen_q    <= 1'b0;
      reg_ren_q    <= 1'b0;
      is_wr_q      <= 1'b0;
      is_sr_q      <= 1'b0;
      rdata_q      <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      cr_wdata_q   <= '0;
    end else begin
      sid_sync_q[0] <= bus.scan_id;
      wen_sync_q[0] <= bus.static_wen;
      ren_sync_q[0] <= bus.static_ren;
      fill_q[0]     <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sid_sync_q[i] <= sid_sync_q[i-1];
        wen_sync_q[i] <= wen_sync_q[i-1];
        ren_sync_q[i] <= ren_sync_q[i-1];
        fill_q[i]     <= fill_q[i-1];
      end
      wen_prev_q   <= primed ? swen : 1'b1;
      ren_prev_q   <= primed ? sren : 1'b1;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sram_wen_q   <= sram_wen_d;
      sram_ren_q   <= sram_ren_d;
      reg_wen_q    <= reg_wen_d;
      reg_ren_q    <= reg_ren_d;
      is_wr_q      <= is_wr_d;
      is_sr_q      <= is_sr_d;
      rdata_q      <= rdata_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      cr_wdata_q   <= cr_wdata_d;
    end
  end

  assign bus.static_rdata = rdata_q;
  assign bus.static_ready = (state_q == ST_DONE);
  assign bus.sram_wen     = sram_wen_q;
  assign bus.sram_ren     = sram_ren_q;
  assign bus.sram_addr    = sram_addr_q;
  assign bus.sram_wdata   = sram_wdata_q;
  assign bus.reg_wen      = reg_wen_q;
  assign bus.reg_ren      = reg_ren_q;
  assign bus.cr_wdata     = cr_wdata_q;

endmodule

// File: tb/tb_scan_sram_bridge.sv
// Directed vector bench for scan_sram_bridge with a simple ready-responder.
module tb_scan_sram_bridge;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scan_sram_bridge_if bus ();

  scan_sram_bridge #(.TIMEOUT(255), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        wr;
    logic [19:0] addr;
    logic [31:0] wdata;
    int          delay;      // strobe cycles before ready; -1 = never
    logic        drop_sid;
    logic [31:0] sram_rd;
    logic [16:0] cr_rd;
    logic [14:0] sr_rd;
    int          exp_sw, exp_sr, exp_rw, exp_rr;
    logic [31:0] exp_rdata;
    logic [10:0] exp_saddr;
    logic [31:0] exp_swdata;
    logic [16:0] exp_crw;
  } vec_t;

  vec_t vecs[10];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_access(input int idx, input vec_t v);
    int  hi[4];
    int  sc;
    bit  done;
    bit  held;
    bit  any_sram, any_reg;
    foreach (hi[k]) hi[k] = 0;
    sc = 0; done = 0;
    @(negedge clk);
    bus.scan_id      = 1'b1;
    bus.static_addr  = v.addr;
    bus.static_wdata = v.wdata;
    bus.sram_rdata   = v.sram_rd;
    bus.cr_rdata     = v.cr_rd;
    bus.sr_rdata     = v.sr_rd;
    if (v.wr) bus.static_wen = 1'b1;
    else      bus.static_ren = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (bus.sram_wen) hi[0]++;
      if (bus.sram_ren) hi[1]++;
      if (bus.reg_wen)  hi[2]++;
      if (bus.reg_ren)  hi[3]++;
      any_sram = bus.sram_wen | bus.sram_ren;
      any_reg  = bus.reg_wen | bus.reg_ren;
      if (any_sram || any_reg) begin
        sc++;
        if (v.drop_sid) bus.scan_id = 1'b0;
      end
      bus.sram_ready = any_sram && (v.delay >= 0) && (sc > v.delay);
      bus.reg_ready  = any_reg  && (v.delay >= 0) && (sc > v.delay);
      if (bus.static_ready) done = 1;
    end
    bus.sram_ready = 1'b0;
    bus.reg_ready  = 1'b0;
    chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d_sram_wen_cycles", idx), 32'(hi[0]), 32'(v.exp_sw));
    chk($sformatf("v%0d_sram_ren_cycles", idx), 32'(hi[1]), 32'(v.exp_sr));
    chk($sformatf("v%0d_reg_wen_cycles", idx),  32'(hi[2]), 32'(v.exp_rw));
    chk($sformatf("v%0d_reg_ren_cycles", idx),  32'(hi[3]), 32'(v.exp_rr));
    chk($sformatf("v%0d_rdata", idx), bus.static_rdata, v.exp_rdata);
    chk($sformatf("v%0d_sram_addr", idx), 32'(bus.sram_addr), 32'(v.exp_saddr));
    chk($sformatf("v%0d_sram_wdata", idx), bus.sram_wdata, v.exp_swdata);
    chk($sformatf("v%0d_cr_wdata", idx), 32'(bus.cr_wdata), 32'(v.exp_crw));
    held = 1;
    repeat (3) begin
      @(negedge clk);
      if (!bus.static_ready) held = 0;
    end
    chk($sformatf("v%0d_ready_held", idx), 32'(held), 32'd1);
    bus.static_wen = 1'b0;
    bus.static_ren = 1'b0;
    bus.scan_id    = 1'b1;
    for (int c = 0; c < 10 && bus.static_ready; c++) @(negedge clk);
    chk($sformatf("v%0d_ready_drop", idx), 32'(bus.static_ready), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  int strobes;
  bit seen;

  initial begin
    //           wr   addr      wdata         dly dsid sram_rd       cr_rd     sr_rd     sw  sr  rw rr  rdata         saddr    swdata        crw
    vecs[0] = '{1'b1, 20'h00123, 32'hCAFE_F00D, 3, 1'b0, 32'h0,        17'h0,    15'h0,    4,  0,  0, 0, 32'h0000_0000, 11'h123, 32'hCAFE_F00D, 17'h0};
    vecs[1] = '{1'b0, 20'h00007, 32'h0,         1, 1'b1, 32'h1234_5678, 17'h0,   15'h0,    0,  2,  0, 0, 32'h1234_5678, 11'h007, 32'hCAFE_F00D, 17'h0};
    vecs[2] = '{1'b0, 20'h40000, 32'h0,         0, 1'b0, 32'h0,        17'h1ABCD, 15'h0,   0,  0,  0, 1, 32'h0001_ABCD, 11'h007, 32'hCAFE_F00D, 17'h0};
    vecs[3] = '{1'b0, 20'h40001, 32'h0,         2, 1'b0, 32'h0,        17'h0,    15'h7FFF, 0,  0,  0, 3, 32'h0000_7FFF, 11'h007, 32'hCAFE_F00D, 17'h0};
    vecs[4] = '{1'b1, 20'h40000, 32'h0005_5A5A, 1, 1'b0, 32'h0,        17'h0,    15'h0,    0,  0,  2, 0, 32'h0000_7FFF, 11'h007, 32'hCAFE_F00D, 17'h15A5A};
    vecs[5] = '{1'b1, 20'h40001, 32'hFFFF_FFFF, 0, 1'b0, 32'h0,        17'h0,    15'h0,    0,  0,  0, 0, 32'h0000_7FFF, 11'h007, 32'hCAFE_F00D, 17'h15A5A};
    vecs[6] = '{1'b0, 20'hC0010, 32'h0,         0, 1'b0, 32'h5555_5555, 17'h0,   15'h0,    0,  0,  0, 0, 32'h0000_0000, 11'h007, 32'hCAFE_F00D, 17'h15A5A};
    vecs[7] = '{1'b1, 20'h00456, 32'h1111_2222, 0, 1'b0, 32'h0,        17'h0,    15'h0,    1,  0,  0, 0, 32'h0000_0000, 11'h456, 32'h1111_2222, 17'h15A5A};
    vecs[8] = '{1'b0, 20'h00010, 32'h0,        -1, 1'b0, 32'h9999_9999, 17'h0,   15'h0,    0, 255, 0, 0, 32'hDEAD_BEEF, 11'h010, 32'h1111_2222, 17'h15A5A};
    vecs[9] = '{1'b0, 20'h40000, 32'h0,         0, 1'b0, 32'h0,        17'h00042, 15'h0,   0,  0,  0, 1, 32'h0000_0042, 11'h000, 32'h0000_0000, 17'h0};

    bus.scan_id = 1'b0; bus.static_wen = 1'b0; bus.static_ren = 1'b0;
    bus.static_addr = '0; bus.static_wdata = '0;
    bus.sram_rdata = '0; bus.sram_ready = 1'b0;
    bus.cr_rdata = '0; bus.sr_rdata = '0; bus.reg_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.static_ready), 32'd0);
    chk("rst_rdata", bus.static_rdata, 32'h0);
    chk("rst_strobes", 32'({bus.sram_wen, bus.sram_ren, bus.reg_wen, bus.reg_ren}), 32'h0);
    chk("rst_sram_addr", 32'(bus.sram_addr), 32'h0);
    chk("rst_sram_wdata", bus.sram_wdata, 32'h0);
    chk("rst_cr_wdata", 32'(bus.cr_wdata), 32'h0);
    rst = 1'b0;
    bus.scan_id = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 9; i++) run_access(i, vecs[i]);

    // write and read rising together on an unmapped address
    bus.static_addr = 20'h80000;
    bus.static_wen = 1'b1; bus.static_ren = 1'b1;
    strobes = 0; seen = 0;
    for (int k = 0; k < SYNC + 2 && !seen; k++) begin
      @(negedge clk);
      if (bus.sram_wen | bus.sram_ren | bus.reg_wen | bus.reg_ren) strobes++;
      if (bus.static_ready) seen = 1;
    end
    chk("simul_ready_in_time", 32'(seen), 32'd1);
    chk("simul_no_strobe", 32'(strobes), 32'd0);
    chk("simul_rdata_kept", bus.static_rdata, 32'hDEAD_BEEF);
    bus.static_wen = 1'b0; bus.static_ren = 1'b0;
    repeat (6) @(negedge clk);
    chk("simul_ready_drop", 32'(bus.static_ready), 32'd0);

    // edge while group not selected is ignored
    bus.scan_id = 1'b0;
    bus.static_addr = 20'h00123;
    bus.static_wen = 1'b1;
    strobes = 0; seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.sram_wen | bus.sram_ren | bus.reg_wen | bus.reg_ren) strobes++;
      if (bus.static_ready) seen = 1;
    end
    chk("sid0_no_strobe", 32'(strobes), 32'd0);
    chk("sid0_no_ready", 32'(seen), 32'd0);
    chk("sid0_addr_kept", 32'(bus.sram_addr), 32'h010);
    bus.static_wen = 1'b0;
    repeat (4) @(negedge clk);
    bus.scan_id = 1'b1;
    repeat (2) @(negedge clk);

    // reset during an SRAM wait
    bus.static_addr = 20'h00010;
    bus.static_ren = 1'b1;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.sram_ren) seen = 1;
    end
    chk("rstmid_ren_started", 32'(seen), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_ren_dropped", 32'(bus.sram_ren), 32'd0);
    chk("rstmid_ready", 32'(bus.static_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    strobes = 0; seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.sram_wen | bus.sram_ren | bus.reg_wen | bus.reg_ren) strobes++;
      if (bus.static_ready) seen = 1;
    end
    chk("rstmid_no_restart", 32'(strobes), 32'd0);
    chk("rstmid_no_ready", 32'(seen), 32'd0);
    chk("rstmid_rdata", bus.static_rdata, 32'h0);
    bus.static_ren = 1'b0;
    repeat (4) @(negedge clk);
    run_access(9, vecs[9]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
